conv_post_pool: RTL and testbench

- Downstream consumer of the convolution engine's 23-bit signed result stream (valid/ready).
- Per conv output: adds a bias, optionally applies ReLU, and max-pools POOL consecutive results.
- Each pooled value is rounded and right-shifted, then saturated back to the 10-bit sample width.
- Results are buffered in a small FIFO with a frame-last flag, ready to feed the next conv stage's x input.

---
 rtl/conv_post_pool.sv | 159 +++++++++++++++
 tb/tb_conv_post_pool.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_post_pool.sv
// Post-processing for the conv engine result stream: bias, optional ReLU, max-pool,
// round/shift/saturate to the sample width, then a small FIFO tagged with frame-last.
module conv_post_pool #(
  parameter int IN_W      = 23,
  parameter int OUT_W     = 10,
  parameter int SHIFT     = 4,
  parameter int POOL      = 2,
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  bias,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int SUM_W = IN_W + 1;
  localparam int Q_W   = IN_W + 2;
  localparam int WIN_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int FR_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(POOL - 1);
  localparam logic [FR_W-1:0]      FR_LAST  = FR_W'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
  localparam logic signed [Q_W-1:0] Q_RND   = Q_W'(2 ** (SHIFT - 1));
  localparam logic signed [Q_W-1:0] Q_MAX   = Q_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [Q_W-1:0] Q_MIN   = ~Q_MAX;

  typedef enum logic {
    ST_EMPTY,
    ST_FILL
  } state_t;

  // Round half toward +inf, then arithmetic shift; the extra headroom bit keeps the add exact.
  function automatic logic signed [Q_W-1:0] round_shift(input logic signed [SUM_W-1:0] m);
    logic signed [Q_W-1:0] t;
    t = {m[SUM_W-1], m};
    t = t + Q_RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [Q_W-1:0] t);
    logic signed [Q_W-1:0] c;
    if (t > Q_MAX)      c = Q_MAX;
    else if (t < Q_MIN) c = Q_MIN;
    else                c = t;
    return c[OUT_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic signed [SUM_W-1:0]   pool_q, pool_d;
  logic [WIN_W-1:0]          win_q, win_d;
  logic [FR_W-1:0]           frame_q, frame_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [OUT_W-1:0]   mem_data_q [DEPTH];
  logic                      mem_last_q [DEPTH];

  logic                      acc, pop, push, push_last, closing;
  logic signed [SUM_W-1:0]   s, r, m;
  logic signed [OUT_W-1:0]   push_data;

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CNT_FULL);
  assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & mem_last_q[rd_ptr_q];

  assign s = {in_data[IN_W-1], in_data} + {bias[IN_W-1], bias};
  assign r = (relu_en && s[SUM_W-1]) ? '0 : s;

  always_comb begin
    state_d   = state_q;
    pool_d    = pool_q;
    win_d     = win_q;
    frame_d   = frame_q;
    push      = 1'b0;
    push_last = 1'b0;
    m         = r;
    acc       = in_valid & in_ready;
    pop       = out_valid & out_ready;
    // A short final window closes with the frame, so pooling never straddles frames.
    closing   = (win_q == WIN_LAST) || (frame_q == FR_LAST);

    case (state_q)
      ST_EMPTY: m = r;
      ST_FILL:  m = (pool_q > r) ? pool_q : r;
      default:  m = r;
    endcase

    if (acc) begin
      frame_d = (frame_q == FR_LAST) ? '0 : frame_q + FR_W'(1);
      if (closing) begin
        push      = 1'b1;
        push_last = (frame_q == FR_LAST);
        win_d     = '0;
        state_d   = ST_EMPTY;
      end else begin
        pool_d  = m;
        win_d   = win_q + WIN_W'(1);
        state_d = ST_FILL;
      end
    end
  end

  assign push_data = saturate(round_shift(m));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      pool_q   <= '0;
      win_q    <= '0;
      frame_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pool_q   <= pool_d;
      win_q    <= win_d;
      frame_q  <= frame_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_last_q[wr_ptr_q] <= push_last;
    end
  end

endmodule

// File: tb/tb_conv_post_pool.sv
// Directed bench for conv_post_pool: table of pooled pairs plus backpressure,
// full-frame and mid-window reset sequences.
module tb_conv_post_pool;

  logic               clk;
  logic               reset;
  logic signed [22:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [22:0] bias;
  logic               relu_en;
  logic signed [9:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  int tests;
  int failed;

  conv_post_pool dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bias     (bias),
    .relu_en  (relu_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int   a;
    int   b;
    int   bias;
    logic relu;
    int   exp_q;
    logic exp_last;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int bs, input logic re,
                              input int q, input logic last);
    vec_t v;
    v.a = a; v.b = b; v.bias = bs; v.relu = re; v.exp_q = q; v.exp_last = last;
    return v;
  endfunction

  // Entered and left at a negedge; the accept happens on the posedge in between.
  task automatic accept(input int d, input int bs, input logic re);
    int n;
    in_data  = 23'(d);
    bias     = 23'(bs);
    relu_en  = re;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp_bp [4];
    logic exp_bl [4];
    tests     = 0;
    failed    = 0;
    reset     = 1'b1;
    in_data   = '0;
    bias      = '0;
    relu_en   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = mk(100, 200, 0, 1'b0, 13, 1'b0);
    vecs[1]  = mk(-100, -50, 0, 1'b0, -3, 1'b0);
    vecs[2]  = mk(-100, -50, 0, 1'b1, 0, 1'b0);
    vecs[3]  = mk(-100, -50, 64, 1'b1, 1, 1'b1);
    vecs[4]  = mk(20000, 0, 0, 1'b0, 511, 1'b0);
    vecs[5]  = mk(-20000, -30000, 0, 1'b0, -512, 1'b0);
    vecs[6]  = mk(4194303, 0, 4194303, 1'b0, 511, 1'b0);
    vecs[7]  = mk(-4194304, -4194304, -4194304, 1'b0, -512, 1'b1);
    vecs[8]  = mk(8, 7, 0, 1'b0, 1, 1'b0);
    vecs[9]  = mk(-9, -200, 0, 1'b0, -1, 1'b0);
    vecs[10] = mk(7, -8, 0, 1'b0, 0, 1'b0);
    vecs[11] = mk(24, 23, 0, 1'b0, 2, 1'b1);

    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      accept(vecs[i].a, vecs[i].bias, vecs[i].relu);
      check($sformatf("vec%0d_half_valid", i), out_valid, 0);
      accept(vecs[i].b, vecs[i].bias, vecs[i].relu);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_q);
      check($sformatf("vec%0d_last", i), out_last, vecs[i].exp_last);
    end
    @(negedge clk);
    check("table_drained", out_valid, 0);

    // Full frame with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      accept(16 * (i + 1), 0, 1'b0);
      if (i % 2 == 0) begin
        check($sformatf("frame%0d_valid", i), out_valid, 0);
      end else begin
        check($sformatf("frame%0d_valid", i), out_valid, 1);
        check($sformatf("frame%0d_data", i), out_data, i + 1);
        check($sformatf("frame%0d_last", i), out_last, (i == 7) ? 1 : 0);
      end
    end

    // Backpressure: fill the FIFO, hold input 9, free one slot, drain in order.
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) accept(16 * i, 0, 1'b0);
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_valid", out_valid, 1);
    check("bp_head", out_data, 2);
    in_data  = 23'(144);
    bias     = '0;
    relu_en  = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_stall%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp_stall%0d_head", k), out_data, 2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_pop_in_ready", in_ready, 1);
    check("bp_after_pop_head", out_data, 4);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_in9_taken_in_ready", in_ready, 1);
    accept(160, 0, 1'b0);
    check("bp_refull_in_ready", in_ready, 0);
    exp_bp = '{4, 6, 8, 10};
    exp_bl = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_drain%0d_valid", k), out_valid, 1);
      check($sformatf("bp_drain%0d_data", k), out_data, exp_bp[k]);
      check($sformatf("bp_drain%0d_last", k), out_last, exp_bl[k]);
      @(negedge clk);
    end
    check("bp_empty", out_valid, 0);

    // Reset mid-window must discard the held sample.
    do_reset();
    out_ready = 1'b1;
    accept(5000, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_valid_during", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid_after", out_valid, 0);
    accept(300, 0, 1'b0);
    check("rst_mid_half_valid", out_valid, 0);
    accept(10, 0, 1'b0);
    check("rst_mid_valid", out_valid, 1);
    check("rst_mid_data", out_data, 19);
    check("rst_mid_last", out_last, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
